aqp_spi_cmd_master: RTL and testbench
=====================================

// Module: aqp_spi_cmd_master
// PURPOSE
// - SPI master (mode 0, MSB first) that frames FPGA-initiated commands to an SPI slave: one cmd byte, then N payload bytes.
// - Frame = ssel_n low, byte 0 = cmd_code, bytes 1..N = payload, ssel_n high. Slave latches the command on ssel_n rising edge.
// - Captures MISO on every payload byte and returns it as a byte stream, so read commands (e.g. 23h/25h) can be issued.
// PARAMETERS
// - CLK_DIV  default 4  clk cycles per SCLK half-period; legal range 2..255.
// PORTS
// - clk         in   1  system clock
// - reset       in   1  asynchronous, active-high reset
// - cmd_start   in   1  1-cycle request; accepted only when busy==0
// - cmd_code    in   8  command byte, sampled on accept
// - cmd_len     in   8  payload byte count N (0..255), sampled on accept
// - tx_data     in   8  payload byte
// - tx_valid    in   1  tx_data valid
// - tx_ready    out  1  payload byte taken when tx_valid&&tx_ready
// - rx_data     out  8  byte shifted in from MISO during a payload byte
// - rx_valid    out  1  1-cycle strobe per payload byte; none for the cmd byte
// - busy        out  1  high from the accept cycle until done
// - done        out  1  1-cycle strobe at frame end
// - spi_ssel_n  out  1  slave select, active low
// - spi_sclk    out  1  serial clock, idles low
// - spi_mosi    out  1  master out
// - spi_miso    in   1  master in; the block adds a 2-flop synchronizer
// BEHAVIOUR
// - Reset values: spi_ssel_n=1, spi_sclk=0, spi_mosi=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0, done=0.
// - Reset is asynchronous. Asserting it mid-frame returns the block to IDLE in the same cycle. No done strobe.
// - States: IDLE -> SETUP -> SHIFT -> (LOAD -> SHIFT)* -> HOLD -> GAP -> IDLE.
// - IDLE: on cmd_start, latch cmd_code/cmd_len, set busy=1, go to SETUP. cmd_start while busy is ignored.
// - SETUP: spi_ssel_n=0 and spi_mosi=cmd_code[7]. Wait CLK_DIV cycles, then go to SHIFT.
// - SHIFT: 8 bits per byte.
//   - sclk rises after each low half-period; MISO is sampled on the rising edge.
//   - sclk falls after CLK_DIV cycles; mosi advances to the next bit on the falling edge.
//   - Byte time = 16*CLK_DIV cycles.
// - After bit 0 of each payload byte: rx_data is valid and rx_valid pulses on the cycle after the final sclk falling edge.
// - LOAD: entered between bytes while bytes remain.
//   - tx_ready=1 until tx_valid; the handshake cycle latches tx_data and drives mosi=tx_data[7].
//   - SCLK stays low and ssel_n stays low for any stall length.
//   - After the handshake, wait CLK_DIV cycles, then enter SHIFT.
// - Byte counter is 9 bits, so N=255 gives 256 bytes total with no wrap. N=0 sends the cmd byte only.
// - HOLD: wait CLK_DIV cycles with sclk low, then spi_ssel_n=1.
// - GAP: ssel_n stays high for 2*CLK_DIV cycles. done pulses on the first GAP cycle; busy clears on the last.
// - tx_ready is never high outside LOAD. Simultaneous cmd_start and done: cmd_start is ignored, because busy is still 1.
// CONFIGURATION
// - AQP_SPIM_ABORT_EN defined:
//   - Adds input `abort` (1 bit).
//   - abort high during SETUP/SHIFT/LOAD finishes the current byte, skips the remaining bytes, then runs HOLD and GAP normally; done pulses.
//   - In LOAD the byte is aborted without a handshake.
// - AQP_SPIM_ABORT_EN undefined: `abort` port absent; every frame always sends 1+N bytes.
// STRUCTURE
// - Package aqp_spim_pkg holds:
//   - state enum (IDLE, SETUP, SHIFT, LOAD, HOLD, GAP);
//   - command constants: 01h RESET, 10h SET_KEYB_MATRIX, 11h SET_HCTRL, 12h WRITE_KBBUF, 20h BUS_ACQUIRE, 21h BUS_RELEASE, 22h MEM_WRITE, 23h MEM_READ, 24h IO_WRITE, 25h IO_READ.
// - Sub-module aqp_spim_shifter: half-period divider, 8-bit TX/RX shift registers, bit counter, byte_done strobe. The top level holds the frame FSM and handshakes.
// TESTING
// - All tests use CLK_DIV=4 and a bench SPI slave model.
// - Reset: outputs at reset values; cmd 12h with N=1 and payload 41h -> slave sees bytes 12h,41h; exactly 16 rising sclk edges; one done pulse.
// - Cmd 23h, N=3, payload 00h,80h,00h, slave returns AAh on byte 3 -> three rx_valid pulses; third rx_data = AAh; ssel_n high for >=8 cycles after the frame.
// - Cmd 10h, N=8, tx_valid withheld for 50 cycles before byte 4 -> sclk stays low and ssel_n stays low through the stall; slave receives all 9 bytes intact.
// - N=0, cmd 01h -> exactly 8 sclk pulses; no tx_ready and no rx_valid; done pulse.
// - Assert reset at bit 3 of byte 2 -> ssel_n=1 and sclk=0 in the same cycle; no done pulse; the next command runs correctly.
// - AQP_SPIM_ABORT_EN: cmd 22h with N=3, abort during byte 1 -> exactly 2 bytes on the wire, then done.

Source files
------------

// File: rtl/aqp_spim_pkg.sv
// aqp_spim_pkg: frame FSM state encoding and SPI slave command codes shared by the
// SPI command master and its users.
package aqp_spim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        LOAD,
        HOLD,
        GAP
    } spim_state_e;

    localparam logic [7:0] CMD_RESET           = 8'h01;
    localparam logic [7:0] CMD_SET_KEYB_MATRIX = 8'h10;
    localparam logic [7:0] CMD_SET_HCTRL       = 8'h11;
    localparam logic [7:0] CMD_WRITE_KBBUF     = 8'h12;
    localparam logic [7:0] CMD_BUS_ACQUIRE     = 8'h20;
    localparam logic [7:0] CMD_BUS_RELEASE     = 8'h21;
    localparam logic [7:0] CMD_MEM_WRITE       = 8'h22;
    localparam logic [7:0] CMD_MEM_READ        = 8'h23;
    localparam logic [7:0] CMD_IO_WRITE        = 8'h24;
    localparam logic [7:0] CMD_IO_READ         = 8'h25;

    function automatic logic cmd_is_read(input logic [7:0] code);
        return code == CMD_MEM_READ || code == CMD_IO_READ;
    endfunction

endpackage

// File: rtl/aqp_spim_shifter.sv
// aqp_spim_shifter: SPI mode 0 byte engine -- half-period divider, TX/RX shift
// registers, bit counter and a byte_done strobe coincident with the last sclk fall.
module aqp_spim_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       run,
    input  logic       spi_miso,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic [7:0] rx_byte,
    output logic       byte_done
);
    logic [7:0] div_q, div_d, tx_q, tx_d, rx_q, rx_d;
    logic [2:0] bit_q, bit_d;
    logic       sclk_q, sclk_d, done_q, done_d;
    logic [1:0] sync_q;
    logic       active, tick, rise, fall;

    always_comb begin
        active = run && !done_q;
        tick   = active && div_q == 8'(CLK_DIV - 1);
        rise   = tick && !sclk_q;
        fall   = tick && sclk_q;
        div_d  = (active && !tick) ? div_q + 8'd1 : 8'd0;
        sclk_d = tick ? !sclk_q : sclk_q;
        rx_d   = rise ? {rx_q[6:0], sync_q[1]} : rx_q;
        tx_d   = load ? load_data : fall ? {tx_q[6:0], 1'b0} : tx_q;
        bit_d  = load ? 3'd0 : fall ? bit_q + 3'd1 : bit_q;
        done_d = fall && bit_q == 3'd7;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            done_q <= 1'b0;
            sync_q <= '0;
        end else begin
            div_q  <= div_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
            done_q <= done_d;
            sync_q <= {sync_q[0], spi_miso};
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_mosi  = tx_q[7];
    assign rx_byte   = rx_q;
    assign byte_done = done_q;

endmodule

// File: rtl/aqp_spi_cmd_master.sv
// aqp_spi_cmd_master: frames a command byte plus N payload bytes on SPI mode 0 and
// returns MISO bytes; AQP_SPIM_ABORT_EN adds an abort input that truncates the frame.
module aqp_spi_cmd_master
    import aqp_spim_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic [7:0] cmd_code,
    input  logic [7:0] cmd_len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
`ifdef AQP_SPIM_ABORT_EN
    input  logic       abort,
`endif
    output logic       spi_ssel_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);
    spim_state_e state_q, state_d;
    logic [8:0]  cnt_q, cnt_d, rem_q, rem_d;
    logic        is_cmd_q, is_cmd_d, loaded_q, loaded_d;
    logic        ssel_n_q, ssel_n_d, done_q, done_d, rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d, sh_data, rx_byte;
    logic        sh_load, byte_done, wait_end, stop;

    aqp_spim_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_data (sh_data),
        .run       (state_q == SHIFT),
        .spi_miso  (spi_miso),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .rx_byte   (rx_byte),
        .byte_done (byte_done)
    );

`ifdef AQP_SPIM_ABORT_EN
    logic abort_q, abort_d;
    // Sticky request; cleared whenever the frame is outside SETUP/SHIFT/LOAD.
    assign abort_d = (state_q inside {SETUP, SHIFT, LOAD}) && (abort_q || abort);
    assign stop    = abort_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) abort_q <= 1'b0;
        else       abort_q <= abort_d;
    end
`else
    assign stop = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 9'd1;
        rem_d      = rem_q;
        is_cmd_d   = is_cmd_q;
        loaded_d   = loaded_q;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        sh_load    = 1'b0;
        sh_data    = cmd_code;
        tx_ready   = 1'b0;
        wait_end   = cnt_q == 9'(CLK_DIV - 1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_start) begin
                    state_d  = SETUP;
                    rem_d    = {1'b0, cmd_len} + 9'd1;
                    is_cmd_d = 1'b1;
                    sh_load  = 1'b1;
                end
            end
            SETUP: if (wait_end) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                cnt_d = '0;
                if (byte_done) begin
                    rem_d      = rem_q - 9'd1;
                    is_cmd_d   = 1'b0;
                    loaded_d   = 1'b0;
                    rx_valid_d = !is_cmd_q;
                    rx_data_d  = is_cmd_q ? rx_data_q : rx_byte;
                    state_d    = (rem_q == 9'd1 || stop) ? HOLD : LOAD;
                end
            end
            LOAD: begin
                if (!loaded_q) begin
                    cnt_d    = '0;
                    tx_ready = !stop;
                    if (stop) begin
                        state_d = HOLD;
                    end else if (tx_valid) begin
                        sh_load  = 1'b1;
                        sh_data  = tx_data;
                        loaded_d = 1'b1;
                    end
                end else if (wait_end) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            HOLD: if (wait_end) begin
                state_d = GAP;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            GAP: if (cnt_q == 9'(2 * CLK_DIV - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        ssel_n_d = !(state_d inside {SETUP, SHIFT, LOAD, HOLD});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            is_cmd_q   <= 1'b0;
            loaded_q   <= 1'b0;
            ssel_n_q   <= 1'b1;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            is_cmd_q   <= is_cmd_d;
            loaded_q   <= loaded_d;
            ssel_n_q   <= ssel_n_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign spi_ssel_n = ssel_n_q;

endmodule

// File: tb/tb_aqp_spi_cmd_master.sv
// tb_aqp_spi_cmd_master: directed scenarios against a clk-sampled SPI mode 0 slave model.
// Define AQP_SPIM_ABORT_EN to build and exercise the abort port.
module tb_aqp_spi_cmd_master;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_start = 1'b0;
    logic [7:0] cmd_code = '0;
    logic [7:0] cmd_len = '0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, rx_valid, busy, done, spi_ssel_n, spi_sclk, spi_mosi, spi_miso;
    logic [7:0] rx_data;
`ifdef AQP_SPIM_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aqp_spi_cmd_master #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .cmd_code   (cmd_code),
        .cmd_len    (cmd_len),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .done       (done),
`ifdef AQP_SPIM_ABORT_EN
        .abort      (abort),
`endif
        .spi_ssel_n (spi_ssel_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    // Slave model: samples MOSI on sclk rise, shifts MISO on sclk fall, resp[i] answers byte i.
    logic [7:0] resp [16];
    logic [7:0] txb  [16];
    logic [7:0] got [$];
    logic [7:0] s_rx = '0, s_tx = '0;
    int         s_bits = 0, s_idx = 0, rises = 0;
    logic       sclk_prev = 1'b0;

    always @(posedge clk) begin
        if (spi_ssel_n) begin
            s_bits <= 0;
            s_idx  <= 0;
            s_tx   <= resp[0];
        end else if (spi_sclk && !sclk_prev) begin
            rises++;
            s_rx   <= {s_rx[6:0], spi_mosi};
            s_bits <= s_bits + 1;
        end else if (!spi_sclk && sclk_prev) begin
            if (s_bits == 8) begin
                got.push_back(s_rx);
                s_bits <= 0;
                s_idx  <= s_idx + 1;
                s_tx   <= resp[(s_idx + 1) & 15];
            end else begin
                s_tx <= {s_tx[6:0], 1'b0};
            end
        end
        sclk_prev <= spi_sclk;
    end
    assign spi_miso = s_tx[7];

    int         done_cnt = 0, rxv_cnt = 0, txr_cnt = 0, gap_cnt = 0;
    logic [7:0] rxq [$];
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (rx_valid) begin
            rxv_cnt++;
            rxq.push_back(rx_data);
        end
        if (tx_ready) txr_cnt++;
        if (spi_ssel_n && busy) gap_cnt++;
    end

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) begin
            resp[i] = 8'h00;
            txb[i]  = 8'h00;
        end
    endtask

    // Issues one command and feeds payload bytes; optionally stalls before payload byte stall_idx.
    task automatic run_frame(input logic [7:0] code, input int len, input int stall_idx,
                             input int stall_cyc, output int viol);
        int k = 0;
        int waited = 0;
        int cyc = 0;
        viol = 0;
        @(negedge clk);
        cmd_code  = code;
        cmd_len   = len[7:0];
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        while (busy && cyc < 20000) begin
            if (tx_valid) begin
                tx_valid = 1'b0;
                k++;
            end
            if (tx_ready && !tx_valid) begin
                if (k == stall_idx && waited < stall_cyc) begin
                    waited++;
                    if (spi_sclk !== 1'b0 || spi_ssel_n !== 1'b0) viol++;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = txb[k & 15];
                end
            end
            @(negedge clk);
            cyc++;
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (cyc >= 20000) begin
            n_bad++;
            $display("FAIL frame_timeout: busy still %b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic test_reset();
        int g0, r0, d0, v;
        repeat (3) @(negedge clk);
        n_cmp += 8;
        if (spi_ssel_n !== 1'b1) begin n_bad++; $display("FAIL reset_ssel_n: got %b want 1", spi_ssel_n); end
        if (spi_sclk !== 1'b0)   begin n_bad++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        if (spi_mosi !== 1'b0)   begin n_bad++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        if (tx_ready !== 1'b0)   begin n_bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        if (rx_data !== 8'h00)   begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        if (rx_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_tables();
        txb[0] = 8'h41;
        g0 = got.size(); r0 = rises; d0 = done_cnt;
        run_frame(8'h12, 1, -1, 0, v);
        repeat (2) @(negedge clk);
        n_cmp += 5;
        if (got.size() - g0 !== 2) begin n_bad++; $display("FAIL wr_bytes: got %0d want 2", got.size() - g0); end
        else begin
            if (got[g0] !== 8'h12)     begin n_bad++; $display("FAIL wr_byte0: got %h want 12", got[g0]); end
            if (got[g0 + 1] !== 8'h41) begin n_bad++; $display("FAIL wr_byte1: got %h want 41", got[g0 + 1]); end
        end
        if (rises - r0 !== 16)   begin n_bad++; $display("FAIL wr_rises: got %0d want 16", rises - r0); end
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL wr_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_read();
        int g0, v0, q0, gp0, v;
        clear_tables();
        txb[0] = 8'h00; txb[1] = 8'h80; txb[2] = 8'h00;
        resp[3] = 8'hAA;
        g0 = got.size(); v0 = rxv_cnt; q0 = rxq.size(); gp0 = gap_cnt;
        run_frame(8'h23, 3, -1, 0, v);
        repeat (2) @(negedge clk);
        n_cmp += 5;
        if (rxv_cnt - v0 !== 3) begin n_bad++; $display("FAIL rd_rx_valid: got %0d want 3", rxv_cnt - v0); end
        else begin
            if (rxq[q0] !== 8'h00)     begin n_bad++; $display("FAIL rd_rx0: got %h want 00", rxq[q0]); end
            if (rxq[q0 + 2] !== 8'hAA) begin n_bad++; $display("FAIL rd_rx2: got %h want AA", rxq[q0 + 2]); end
        end
        if (gap_cnt - gp0 < 8) begin n_bad++; $display("FAIL rd_gap: got %0d want >=8", gap_cnt - gp0); end
        if (got.size() - g0 !== 4 || got[g0] !== 8'h23 || got[g0 + 2] !== 8'h80)
            begin n_bad++; $display("FAIL rd_wire: got %0d bytes want 4 (23 00 80 00)", got.size() - g0); end
    endtask

    task automatic test_stall();
        int g0, r0, v, bad;
        clear_tables();
        for (int i = 0; i < 8; i++) txb[i] = 8'(8'hC1 + 8'(i * 7));
        g0 = got.size(); r0 = rises;
        run_frame(8'h10, 8, 3, 50, v);
        repeat (2) @(negedge clk);
        bad = 0;
        n_cmp += 4;
        if (v !== 0) begin n_bad++; $display("FAIL stall_lines: %0d stall cycles with sclk/ssel_n not low, want 0", v); end
        if (got.size() - g0 !== 9) begin n_bad++; $display("FAIL stall_bytes: got %0d want 9", got.size() - g0); end
        else begin
            if (got[g0] !== 8'h10) bad++;
            for (int i = 0; i < 8; i++) if (got[g0 + 1 + i] !== txb[i]) bad++;
            if (bad != 0) begin n_bad++; $display("FAIL stall_data: %0d bytes differ, want 0", bad); end
        end
        if (rises - r0 !== 72) begin n_bad++; $display("FAIL stall_rises: got %0d want 72", rises - r0); end
    endtask

    task automatic test_zero_len();
        int g0, r0, d0, t0, v0, v;
        clear_tables();
        g0 = got.size(); r0 = rises; d0 = done_cnt; t0 = txr_cnt; v0 = rxv_cnt;
        run_frame(8'h01, 0, -1, 0, v);
        repeat (2) @(negedge clk);
        n_cmp += 5;
        if (rises - r0 !== 8)    begin n_bad++; $display("FAIL n0_rises: got %0d want 8", rises - r0); end
        if (txr_cnt - t0 !== 0)  begin n_bad++; $display("FAIL n0_tx_ready: got %0d want 0", txr_cnt - t0); end
        if (rxv_cnt - v0 !== 0)  begin n_bad++; $display("FAIL n0_rx_valid: got %0d want 0", rxv_cnt - v0); end
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL n0_done: got %0d want 1", done_cnt - d0); end
        if (got.size() - g0 !== 1 || got[g0] !== 8'h01)
            begin n_bad++; $display("FAIL n0_wire: got %0d bytes want 1 (01)", got.size() - g0); end
    endtask

    task automatic test_mid_reset();
        int g0, r0, d0, v;
        clear_tables();
        txb[0] = 8'h33; txb[1] = 8'h66;
        r0 = rises; d0 = done_cnt;
        fork
            run_frame(8'h24, 2, -1, 0, v);
            begin
                int t = 0;
                while (rises - r0 < 19 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                n_cmp++;
                if (t >= 2000) begin n_bad++; $display("FAIL mr_wait: reached %0d rises, want 19", rises - r0); end
                reset = 1'b1;
                #1;
                n_cmp += 2;
                if (spi_ssel_n !== 1'b1) begin n_bad++; $display("FAIL mr_ssel_n: got %b want 1", spi_ssel_n); end
                if (spi_sclk !== 1'b0)   begin n_bad++; $display("FAIL mr_sclk: got %b want 0", spi_sclk); end
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        n_cmp += 2;
        if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL mr_done: got %0d want 0", done_cnt - d0); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL mr_busy: got %b want 0", busy); end
        txb[0] = 8'h5A;
        g0 = got.size(); d0 = done_cnt;
        run_frame(8'h12, 1, -1, 0, v);
        repeat (2) @(negedge clk);
        n_cmp += 2;
        if (got.size() - g0 !== 2 || got[g0] !== 8'h12 || got[g0 + 1] !== 8'h5A)
            begin n_bad++; $display("FAIL mr_next_wire: got %0d bytes want 2 (12 5A)", got.size() - g0); end
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL mr_next_done: got %0d want 1", done_cnt - d0); end
    endtask

`ifdef AQP_SPIM_ABORT_EN
    task automatic test_abort();
        int g0, r0, d0, v;
        clear_tables();
        txb[0] = 8'h11; txb[1] = 8'h22; txb[2] = 8'h33;
        g0 = got.size(); r0 = rises; d0 = done_cnt;
        fork
            run_frame(8'h22, 3, -1, 0, v);
            begin
                int t = 0;
                while (rises - r0 < 10 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        n_cmp += 3;
        if (got.size() - g0 !== 2) begin n_bad++; $display("FAIL ab_bytes: got %0d want 2", got.size() - g0); end
        if (rises - r0 !== 16)     begin n_bad++; $display("FAIL ab_rises: got %0d want 16", rises - r0); end
        if (done_cnt - d0 !== 1)   begin n_bad++; $display("FAIL ab_done: got %0d want 1", done_cnt - d0); end
    endtask
`endif

    initial begin
        clear_tables();
        test_reset();
        test_read();
        test_stall();
        test_zero_len();
        test_mid_reset();
`ifdef AQP_SPIM_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
